// File: rtl/parity_arbiter_jdl25175.sv
// Two-requester round-robin arbiter feeding a shared 9-bit parity checker and one result register.
// Optional per-requester mismatch counters are enabled with macro PARITY_ERRCNT_EN.
module parity_arbiter_jdl25175 #(
    parameter int unsigned PRIORITY_INIT = 0,
    parameter int unsigned ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [8:0]          req0_data,
    input  logic                req0_exp,
    input  logic                req1_valid,
    input  logic [8:0]          req1_data,
    input  logic                req1_exp,
    output logic                req0_ready,
    output logic                req1_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_id,
    output logic [8:0]          out_data,
    output logic                out_even,
    output logic                out_odd,
    output logic                out_err
`ifdef PARITY_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_cnt0,
    output logic [ERRCNT_W-1:0] err_cnt1
`endif
);

    localparam int unsigned DATA_W = 9;

    if (PRIORITY_INIT > 1) begin : g_bad_prio
        $error("PRIORITY_INIT must be 0 or 1");
    end
    if (ERRCNT_W == 0) begin : g_bad_errcnt_w
        $error("ERRCNT_W must be at least 1");
    end

    logic              r_out_valid;
    logic              r_out_id;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_even;
    logic              r_out_odd;
    logic              r_out_err;
    logic              r_ptr;

    logic              w_slot_free;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grant;
    logic              w_sel_id;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_exp;
    logic              w_odd;
    logic              w_even;
    logic              w_err;

    // Grant selection: a lone requester wins, a tie goes to the pointer, nothing while in reset or stalled.
    always_comb begin
        w_slot_free = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_slot_free = !r_out_valid || out_ready;
        if (!reset && w_slot_free) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = (r_ptr == 1'b0);
                w_gnt1 = (r_ptr == 1'b1);
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_grant = w_gnt0 || w_gnt1;
    assign w_sel_id = w_gnt1;

    // Shared parity unit operates on whichever word is granted.
    always_comb begin
        w_sel_data = req0_data;
        w_sel_exp  = req0_exp;
        if (w_sel_id) begin
            w_sel_data = req1_data;
            w_sel_exp  = req1_exp;
        end
    end

    assign w_odd  = ^w_sel_data;
    assign w_even = ~w_odd;
    assign w_err  = w_odd ^ w_sel_exp;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Result register and round-robin pointer; a grant overwrites any result drained this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_out_data  <= '0;
            r_out_even  <= 1'b0;
            r_out_odd   <= 1'b0;
            r_out_err   <= 1'b0;
            r_ptr       <= 1'(PRIORITY_INIT);
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_id    <= w_sel_id;
            r_out_data  <= w_sel_data;
            r_out_even  <= w_even;
            r_out_odd   <= w_odd;
            r_out_err   <= w_err;
            r_ptr       <= ~w_sel_id;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_data  = r_out_data;
    assign out_even  = r_out_even;
    assign out_odd   = r_out_odd;
    assign out_err   = r_out_err;

`ifdef PARITY_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt0;
    logic [ERRCNT_W-1:0] r_err_cnt1;

    // Saturating mismatch counters, bumped when an erroneous result is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt0 <= '0;
            r_err_cnt1 <= '0;
        end else if (w_grant && w_err) begin
            if (!w_sel_id && (r_err_cnt0 != {ERRCNT_W{1'b1}})) begin
                r_err_cnt0 <= r_err_cnt0 + ERRCNT_W'(1);
            end
            if (w_sel_id && (r_err_cnt1 != {ERRCNT_W{1'b1}})) begin
                r_err_cnt1 <= r_err_cnt1 + ERRCNT_W'(1);
            end
        end
    end

    assign err_cnt0 = r_err_cnt0;
    assign err_cnt1 = r_err_cnt1;
`endif

endmodule

// File: tb/tb_parity_arbiter_jdl25175.sv
// Self-checking bench for parity_arbiter_jdl25175: directed scenarios then random traffic against a
// transaction-level model. Counter checks are compiled in when PARITY_ERRCNT_EN is defined.
module tb_parity_arbiter_jdl25175;

    localparam int unsigned PINIT = 0;
    localparam int unsigned CW    = 2;
    localparam int          CMAX  = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid, req0_exp, req1_exp;
    logic [8:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       out_valid, out_ready, out_id, out_even, out_odd, out_err;
    logic [8:0] out_data;
`ifdef PARITY_ERRCNT_EN
    logic [CW-1:0] err_cnt0, err_cnt1;
`endif

    parity_arbiter_jdl25175 #(.PRIORITY_INIT(PINIT), .ERRCNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_exp   (req0_exp),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_exp   (req1_exp),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_data   (out_data),
        .out_even   (out_even),
        .out_odd    (out_odd),
        .out_err    (out_err)
`ifdef PARITY_ERRCNT_EN
        ,
        .err_cnt0   (err_cnt0),
        .err_cnt1   (err_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: held result, favoured requester, mismatch tallies.
    bit       m_valid;
    int       m_id;
    bit [8:0] m_data;
    int       m_odd;
    int       m_err;
    int       m_fav;
    int       m_cnt [2];
    int       m_last_gnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check readies against the model, clock, update model, check registered outputs.
    task automatic cycle(input bit rst, input bit v0, input logic [8:0] d0, input bit e0,
                         input bit v1, input logic [8:0] d1, input bit e1, input bit ordy);
        int g;
        bit [8:0] wd;
        int we;
        reset = rst; req0_valid = v0; req0_data = d0; req0_exp = e0;
        req1_valid = v1; req1_data = d1; req1_exp = e1; out_ready = ordy;
        #1;
        g = -1;
        if (!rst && (!m_valid || ordy)) begin
            if (v0 && v1) g = m_fav;
            else if (v0) g = 0;
            else if (v1) g = 1;
        end
        chk("req0_ready", req0_ready, 32'(g == 0));
        chk("req1_ready", req1_ready, 32'(g == 1));
        @(posedge clk);
        #1;
        m_last_gnt = g;
        if (rst) begin
            m_valid = 0; m_id = 0; m_data = '0; m_odd = 0; m_err = 0;
            m_fav = int'(PINIT); m_cnt[0] = 0; m_cnt[1] = 0;
        end else if (g >= 0) begin
            wd = (g == 0) ? d0 : d1;
            we = (g == 0) ? int'(e0) : int'(e1);
            m_valid = 1; m_id = g; m_data = wd;
            m_odd = $countones(wd) % 2;
            m_err = (m_odd != we) ? 1 : 0;
            m_fav = 1 - g;
            if (m_err == 1 && m_cnt[g] < CMAX) m_cnt[g] = m_cnt[g] + 1;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        chk("out_valid", out_valid, 32'(m_valid));
        if (m_valid) begin
            chk("out_id", out_id, m_id);
            chk("out_data", out_data, 32'(m_data));
            chk("out_odd", out_odd, m_odd);
            chk("out_even", out_even, 1 - m_odd);
            chk("out_err", out_err, m_err);
        end
`ifdef PARITY_ERRCNT_EN
        chk("err_cnt0", err_cnt0, m_cnt[0]);
        chk("err_cnt1", err_cnt1, m_cnt[1]);
`endif
    endtask

    task automatic idle(input bit rst, input bit ordy);
        cycle(rst, 0, 9'h0, 0, 0, 9'h0, 0, ordy);
    endtask

    initial begin
        bit [8:0] snap;
        int       exp_id;
        m_valid = 0; m_id = 0; m_data = '0; m_odd = 0; m_err = 0;
        m_fav = int'(PINIT); m_cnt[0] = 0; m_cnt[1] = 0; m_last_gnt = -1;

        // Reset holds readies low even with requests pending; outputs come out zero.
        cycle(1, 1, 9'h155, 1, 1, 9'h0AA, 0, 1);
        idle(1, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_id", out_id, 0);
        chk("rst_data", out_data, 0);
        chk("rst_even", out_even, 0);
        chk("rst_odd", out_odd, 0);
        chk("rst_err", out_err, 0);

        // Single request of zero word.
        cycle(0, 1, 9'h000, 0, 0, 9'h0, 0, 1);
        chk("d1_valid", out_valid, 1);
        chk("d1_id", out_id, 0);
        chk("d1_even", out_even, 1);
        chk("d1_odd", out_odd, 0);
        chk("d1_err", out_err, 0);
        idle(0, 1);
        chk("drain_clears", out_valid, 0);

        // Both valid every cycle from the reset pointer: 0,1,0,1 back-to-back.
        idle(1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 9'(i * 3 + 1), 0, 1, 9'(i * 5 + 2), 1, 1);
            chk("alt_id", out_id, i % 2);
            chk("alt_valid", out_valid, 1);
        end

        // Odd word against exp=0 from requester 1.
        idle(1, 1);
        cycle(0, 0, 9'h0, 0, 1, 9'h1FF, 0, 1);
        chk("d3_err", out_err, 1);
        chk("d3_odd", out_odd, 1);
`ifdef PARITY_ERRCNT_EN
        chk("d3_cnt1", err_cnt1, 1);
`endif

        // Stall: fill, then five stalled cycles, then release to the favoured requester.
        cycle(0, 1, 9'h0F3, 1, 1, 9'h13C, 0, 0);
        snap = m_data;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 9'(i + 7), 0, 1, 9'(i + 9), 1, 0);
            chk("stall_r0", req0_ready, 0);
            chk("stall_r1", req1_ready, 0);
            chk("stall_data", out_data, 32'(snap));
        end
        exp_id = m_fav;
        cycle(0, 1, 9'h021, 0, 1, 9'h042, 0, 1);
        chk("release_id", out_id, exp_id);

        // Reset while holding a result.
        chk("pre_rst_valid", out_valid, 1);
        idle(1, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_err", out_err, 0);
        cycle(0, 1, 9'h003, 0, 1, 9'h005, 0, 1);
        chk("post_rst_id", out_id, PINIT);

`ifdef PARITY_ERRCNT_EN
        // Five mismatches from requester 0 saturate a 2-bit counter.
        idle(1, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 9'h001, 0, 0, 9'h0, 0, 1);
            chk("sat_cnt0", err_cnt0, (i < 3) ? i + 1 : 3);
        end
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  1'($urandom), 9'($urandom), 1'($urandom),
                  1'($urandom), 9'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_arbiter_jdl25175.md
PARITY_ARBITER_JDL25175 -- requirements
Module: parity_arbiter_jdl25175

Interface
REQ-001 The block SHALL have parameter PRIORITY_INIT, default 0, giving the round-robin pointer value after reset (0 = requester 0 favoured).
REQ-002 The block SHALL have parameter ERRCNT_W, default 8, giving the width of each mismatch counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have ports req0_valid / req1_valid, input, 1, requester word present.
REQ-007 The block SHALL have ports req0_data / req1_data, input, 9, word to be parity-checked.
REQ-008 The block SHALL have ports req0_exp / req1_exp, input, 1, expected value of the odd output for that word.
REQ-009 The block SHALL have ports req0_ready / req1_ready, output, 1, word accepted this cycle.
REQ-010 The block SHALL have port out_valid, output, 1, result register holds a result.
REQ-011 The block SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-012 The block SHALL have port out_id, output, 1, requester index of the held result.
REQ-013 The block SHALL have port out_data, output, 9, word of the held result.
REQ-014 The block SHALL have ports out_even / out_odd, output, 1 each, 9-bit even/odd parity of out_data.
REQ-015 The block SHALL have port out_err, output, 1, out_odd differs from the captured exp bit.
REQ-016 The block SHALL have ports err_cnt0 / err_cnt1, output, ERRCNT_W, per-requester mismatch counts; these exist only when PARITY_ERRCNT_EN is defined.

Function
REQ-017 The block SHALL contain a single shared parity unit: odd = XOR of all 9 bits; even = NOT odd.
REQ-018 The block SHALL have one result register; a slot is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
REQ-019 Grant rule: only one valid -> grant it; both valid -> grant the requester named by the pointer; none valid, or slot not free -> no grant.
REQ-020 reqN_ready SHALL be combinational: high only for the granted requester; at most one ready per cycle.
REQ-021 On a grant, the next edge SHALL load the result register with id, data, even, odd and err, and set out_valid=1 (latency 1 cycle).
REQ-022 On a grant to requester i, the pointer SHALL become NOT i; with no grant, the pointer SHALL hold.
REQ-023 When out_valid=1, out_ready=0: all outputs SHALL hold stable, both readies SHALL be 0, and the pointer SHALL hold.
REQ-024 Drain with no grant (out_ready=1, no valid requester) SHALL clear out_valid at the next edge.
REQ-025 Drain and grant in the same cycle SHALL replace the result back-to-back, with no bubble.
REQ-026 out_* fields are don't-care while out_valid=0, but SHALL be zero after reset.

Reset
REQ-027 While reset=1 at an edge: out_valid, out_id, out_data, out_even, out_odd, out_err SHALL become 0, the pointer SHALL become PRIORITY_INIT, and the counters SHALL become 0.
REQ-028 While reset=1: req0_ready and req1_ready SHALL be 0, and no word SHALL be accepted.
REQ-029 Reset mid-transaction SHALL discard the held result without handshake.

Configuration
REQ-030 With macro PARITY_ERRCNT_EN defined, the err_cnt0/err_cnt1 ports SHALL exist.
REQ-031 Each counter SHALL increment by 1 when a result with err=1 from its requester is loaded.
REQ-032 Each counter SHALL saturate at 2^ERRCNT_W-1.
REQ-033 Without PARITY_ERRCNT_EN, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Directed: req0 only, data=9'h000, exp=0, out_ready=1 -> next cycle out_valid=1, id=0, even=1, odd=0, err=0.
REQ-035 Directed: both valid every cycle, PRIORITY_INIT=0, out_ready=1 -> grants alternate 0,1,0,1; results go back-to-back with no idle cycle.
REQ-036 Directed: req1 data=9'h1FF (odd=1), exp=0 -> out_err=1; with PARITY_ERRCNT_EN, err_cnt1 goes 0 -> 1.
REQ-037 Directed: out_ready=0 for 5 cycles with both valid -> readies 0, outputs frozen; then out_ready=1 -> next grant goes to the pointer's requester.
REQ-038 Directed: reset=1 while out_valid=1 -> next cycle all outputs 0, pointer=PRIORITY_INIT.
REQ-039 Directed: with PARITY_ERRCNT_EN, ERRCNT_W=2, five mismatches from req0 -> err_cnt0 sequence 1,2,3,3,3.
